systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 125 ++++++++++++
 tb/tb_systolic_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic array: clear C rows, feed skewed A/B for STEPS cycles, drain rows under out_ready backpressure.
// Moore outputs decoded from state/counters; optional CLEAR phase enabled by SYSTOLIC_CTRL_CLEAR_EN (else results accumulate onto prior C).
module systolic_ctrl #(
    parameter int DIM   = 8,
    parameter int STEPS = 3*DIM-2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     out_ready,
    output logic                     arr_en,
    output logic                     arr_WrEn,
    output logic [$clog2(DIM)-1:0]   arr_Crow,
    output logic                     clr_sel,
    output logic [$clog2(STEPS)-1:0] feed_step,
    output logic                     feed_valid,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(DIM);
    localparam int SW = $clog2(STEPS);
    localparam logic [CW-1:0] ROW_LAST  = CW'(DIM-1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] row_cnt, row_nxt;
    logic [SW-1:0] step_cnt, step_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            row_cnt  <= row_nxt;
            step_cnt <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_cnt;
        step_nxt  = step_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef SYSTOLIC_CTRL_CLEAR_EN
                    state_nxt = S_CLEAR;
`else
                    state_nxt = S_COMPUTE;
`endif
                end
            end
            S_CLEAR: begin
                if (row_cnt == ROW_LAST) begin
                    state_nxt = S_COMPUTE;
                    row_nxt   = '0;
                end else begin
                    row_nxt = row_cnt + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (step_cnt == STEP_LAST) begin
                    state_nxt = S_DRAIN;
                    step_nxt  = '0;
                end else begin
                    step_nxt = step_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // a row retires only on the out_valid/out_ready handshake
                if (out_ready) begin
                    if (row_cnt == ROW_LAST) begin
                        state_nxt = S_DONE;
                        row_nxt   = '0;
                    end else begin
                        row_nxt = row_cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                row_nxt   = '0;
                step_nxt  = '0;
            end
        endcase
        if (abort && (state == S_CLEAR || state == S_COMPUTE || state == S_DRAIN)) begin
            state_nxt = S_IDLE;
            row_nxt   = '0;
            step_nxt  = '0;
        end
    end

    assign arr_en     = (state == S_COMPUTE);
    assign feed_valid = (state == S_COMPUTE);
    assign out_valid  = (state == S_DRAIN);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign feed_step  = (state == S_COMPUTE) ? step_cnt : '0;
    assign arr_Crow   = (state == S_CLEAR || state == S_DRAIN) ? row_cnt : '0;

`ifdef SYSTOLIC_CTRL_CLEAR_EN
    assign arr_WrEn = (state == S_CLEAR);
    assign clr_sel  = (state == S_CLEAR);
`else
    assign arr_WrEn = 1'b0;
    assign clr_sel  = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: table of run scenarios checked cycle by cycle against a phase-timing model plus feed/drain scoreboards.
module tb_systolic_ctrl;

    localparam int DIM   = 8;
    localparam int STEPS = 3*DIM-2;
    localparam int CW    = $clog2(DIM);
    localparam int SW    = $clog2(STEPS);
`ifdef SYSTOLIC_CTRL_CLEAR_EN
    localparam int CLR = DIM;
    localparam int NOM = 39;
`else
    localparam int CLR = 0;
    localparam int NOM = 31;
`endif
    localparam int D0 = CLR + STEPS + 1;

    logic clk = 1'b0;
    logic rst_n, start, abort, out_ready;
    logic arr_en, arr_WrEn, clr_sel, feed_valid, out_valid, busy, done;
    logic [CW-1:0] arr_Crow;
    logic [SW-1:0] feed_step;

    always #5 clk = ~clk;

    systolic_ctrl #(.DIM(DIM), .STEPS(STEPS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
        .arr_en(arr_en), .arr_WrEn(arr_WrEn), .arr_Crow(arr_Crow), .clr_sel(clr_sel),
        .feed_step(feed_step), .feed_valid(feed_valid), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic          en;
        logic          wr;
        logic [CW-1:0] crow;
        logic          clr;
        logic [SW-1:0] step;
        logic          fv;
        logic          ov;
        logic          busy;
        logic          done;
    } obs_t;

    obs_t act, expv;
    assign act = {arr_en, arr_WrEn, arr_Crow, clr_sel, feed_step, feed_valid, out_valid, busy, done};

    typedef struct {
        string name;
        int    srow;
        int    slen;
        int    abort_at;
        bit    hold;
        int    exp_done;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int feed_q[$];
    int row_q[$];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    function automatic obs_t model(input int p, input int srow, input int slen);
        obs_t o;
        int   dn, k;
        o  = '0;
        dn = D0 + DIM + slen;
        if (p >= 1 && p <= CLR) begin
            o.wr = 1'b1; o.clr = 1'b1; o.busy = 1'b1;
            o.crow = CW'(p - 1);
        end else if (p >= CLR + 1 && p <= CLR + STEPS) begin
            o.en = 1'b1; o.fv = 1'b1; o.busy = 1'b1;
            o.step = SW'(p - CLR - 1);
        end else if (p >= D0 && p < dn) begin
            k = p - D0;
            o.ov = 1'b1; o.busy = 1'b1;
            o.crow = CW'((k < srow) ? k : ((k < srow + slen) ? srow : k - slen));
        end else if (p == dn) begin
            o.done = 1'b1; o.busy = 1'b1;
        end
        return o;
    endfunction

    function automatic bit rdy(input int p, input int srow, input int slen);
        int k;
        k = p - D0;
        return !(slen > 0 && k >= srow && k < srow + slen);
    endfunction

    task automatic push_run();
        for (int i = 0; i < STEPS; i++) feed_q.push_back(i);
        for (int i = 0; i < DIM; i++) row_q.push_back(i);
    endtask

    task automatic run_op(input vec_t v);
        int dn, last, p, done_seen, e;
        dn = D0 + DIM + v.slen;
        feed_q.delete();
        row_q.delete();
        push_run();
        last = (v.abort_at >= 0) ? v.abort_at + 1 : (v.hold ? dn + 3 : dn + 1);
        done_seen = -1;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            p = (v.hold && c > dn) ? c - (dn + 1) : c;
            if (v.hold && c == dn + 1) push_run();
            start     = (c == 0) || (v.hold && c <= dn + 2);
            abort     = (c == v.abort_at);
            out_ready = rdy(p, v.srow, v.slen);
            @(negedge clk);
            if (v.abort_at >= 0 && c > v.abort_at) expv = '0;
            else expv = model(p, v.srow, v.slen);
            chk($sformatf("%s.cyc%0d", v.name, c), act, expv);
            if (feed_valid) begin
                if (feed_q.size() == 0) chk($sformatf("%s.feed_extra%0d", v.name, c), 1, 0);
                else begin
                    e = feed_q.pop_front();
                    chk($sformatf("%s.feed_step%0d", v.name, c), feed_step, e);
                end
            end
            if (out_valid && out_ready) begin
                if (row_q.size() == 0) chk($sformatf("%s.row_extra%0d", v.name, c), 1, 0);
                else begin
                    e = row_q.pop_front();
                    chk($sformatf("%s.drain_row%0d", v.name, c), arr_Crow, e);
                end
            end
            if (done && done_seen < 0) done_seen = c;
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        chk($sformatf("%s.done_cycle", v.name), done_seen, v.exp_done);
        if (v.abort_at < 0 && !v.hold)
            chk($sformatf("%s.sb_left", v.name), feed_q.size() + row_q.size(), 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"nominal",      0, 0, -1,      1'b0, NOM};
        vecs[1] = '{"bp_row3",      3, 5, -1,      1'b0, NOM + 5};
        vecs[2] = '{"bp_row0",      0, 2, -1,      1'b0, NOM + 2};
        vecs[3] = '{"bp_lastrow",   DIM-1, 3, -1,  1'b0, NOM + 3};
        vecs[4] = '{"abort_comp",   0, 0, 15,      1'b0, -1};
        vecs[5] = '{"after_abort",  0, 0, -1,      1'b0, NOM};
        vecs[6] = '{"abort_drain",  2, 2, D0 + 3,  1'b0, -1};
        vecs[7] = '{"abort_early",  0, 0, 3,       1'b0, -1};
        vecs[8] = '{"hold_start",   0, 0, NOM + 2, 1'b1, NOM};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_state", act, '0);

        // start already high when reset releases: must be taken on the first edge
        start = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_start", act, model(1, 0, 0));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_first", act, '0);

        for (int i = 0; i < 9; i++) run_op(vecs[i]);

        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre_reset_cyc20", act, model(20, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", act, '0);
        repeat (2) @(negedge clk);
        chk("reset_held", act, '0);
        rst_n = 1'b1;
        run_op(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
